ram_read_shim: RTL and testbench
================================

Name: ram_read_shim

Overview:
- Read-side counterpart of the raster RAM write shim.
- On a consumer fetch request, reads two consecutive RAM_WORD-wide words from a LiteX RAM DMA-style read port and reassembles them into one signed DAT_WID sample. The low word is at the lower address.
- Walks a linear buffer at BASE_ADDR, so samples written by the raster writer can be replayed or read back by the host or a simulator.
- Constraint: RAM_WORD < DAT_WID < 2*RAM_WORD.

Parameters:
- BASE_ADDR, 32'h1000000, buffer base address.
- MAX_BYTE_WID, 13, width of the byte offset counter; the buffer is 2^MAX_BYTE_WID bytes.
- DAT_WID, 24, reassembled sample width (signed).
- RAM_WORD, 16, width of one RAM transfer.
- RAM_WID, 32, address bus width.
- ADDR_STEP, 8, offset advance per RAM word; matches the writer's stride (RAM_WORD/2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- fetch  in  1  consumer request; level, 4-phase
- rewind  in  1  zero the offset; honoured only in IDLE
- data  out  DAT_WID  reassembled signed sample
- finished  out  1  data valid; held until fetch drops
- addr  out  RAM_WID  BASE_ADDR + zero-extended offset (combinational)
- read  out  1  RAM read request
- word  in  RAM_WORD  RAM read data, sampled when read && valid
- valid  in  1  RAM acknowledges the current request
- sign_err  out  1  only with RAM_SIGN_CHECK_EN

Behaviour:
- Reset (rst_n=0 at posedge), applies in any state and aborts any transfer in flight:
  - state=IDLE, offset=0, read=0, finished=0, data=0, low register=0, sign_err=0.
- IDLE:
  - rewind=1: offset<=0. rewind has priority over fetch in the same cycle; fetch is taken the following cycle.
  - else fetch=1: read<=1, go LOW.
- LOW: on valid:
  - low register <= word; read<=0; offset<=offset+ADDR_STEP; go HIGH.
- HIGH:
  - if read=0: read<=1 (mandatory one-cycle gap between requests).
  - else on valid: data <= {word[DAT_WID-RAM_WORD-1:0], low register}; read<=0; offset<=offset+ADDR_STEP; finished<=1; go DONE.
- DONE: on fetch=0: finished<=0, go IDLE.
- Handshake rules:
  - valid is ignored whenever read=0, and in IDLE/DONE.
  - read stays high until valid is seen; there is no timeout.
  - data is stable from finished rising until the next completed read.
- Minimum latency, valid tied high: fetch sampled at cycle 0; read high at cycles 1 and 3; finished rises at cycle 4.
- The offset wraps modulo 2^MAX_BYTE_WID silently, so addr wraps inside the buffer.
- rewind asserted outside IDLE is ignored, not queued.
- A fetch that stays high after DONE→IDLE starts a new read. The consumer must drop fetch to stop reads.
- word bits above DAT_WID-RAM_WORD in the high word are discarded.

Optional Feature:
- Macro: RAM_SIGN_CHECK_EN.
- Defined:
  - On high-word capture, checks that word[RAM_WORD-1:DAT_WID-RAM_WORD-1] are all equal (valid sign extension).
  - If they are not, sign_err<=1. sign_err is sticky until reset or a rewind in IDLE.
  - data is still produced normally.
- Undefined: the sign_err port is absent and no check logic is built.

Decomposition:
- Shared package ram_shim_pkg holds:
  - state encodings IDLE/LOW/HIGH/DONE;
  - the default ADDR_STEP;
  - the shared address-formation helper BASE_ADDR + zero-extended offset, reused by the writer.
- No sub-module. The block is one FSM plus offset counter and capture registers.

Test Plan:
- Reset, then fetch=1 with valid tied high; RAM returns 16'h5678 at offset 0 and 16'h0012 at offset 8:
  - data=24'h125678; finished at cycle 4; addr sequence 0x1000000, 0x1000008; next offset 16.
- Negative sample: words 16'hFFFF then 16'hFF80:
  - data=24'h80FFFF, negative as signed.
  - With RAM_SIGN_CHECK_EN, high word 16'h1280 sets sign_err=1 and data=24'h80FFFF.
- valid delayed 5 cycles per word:
  - read held high through each wait; exactly one gap cycle between the two requests; finished only after the second valid.
- Wrap: 512 back-to-back fetches (offset 0→8184, then 8192 wraps to 0):
  - 513th fetch reads addr 0x1000000.
- rewind=1 during HIGH is ignored; rewind=1 together with fetch in IDLE:
  - offset=0; read rises one cycle later than it would for fetch alone.
- rst_n=0 while in HIGH with read=1:
  - next cycle read=0, finished=0, data=0, offset=0; a subsequent fetch reads from BASE_ADDR.

Source files
------------

// File: rtl/ram_shim_pkg.sv
// ram_shim_pkg: definitions shared by the raster RAM shims (read and write).
//   - FSM state encodings IDLE/LOW/HIGH/DONE
//   - default per-word address stride
//   - address-formation helper: base + zero-extended byte offset
// No ports; the writer reuses the same package.
package ram_shim_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Byte offset advance per RAM word; equals the writer's stride.
    localparam int ADDR_STEP_DEFAULT = 8;

    // Both shims form addresses the same way.
    // Callers widen the base and offset to 64 bits and then truncate the
    // result to their own bus width.
    function automatic logic [63:0] shim_addr(input logic [63:0] base,
                                              input logic [63:0] offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/ram_read_shim_if.sv
// ram_read_shim_if: bundles the consumer handshake and the RAM read port.
//   Consumer side: fetch, rewind (in); data, finished (out)
//   RAM side:      addr, read (out); word, valid (in)
//   sign_err exists only when RAM_SIGN_CHECK_EN is defined.
// modport master is the shim; modport slave is the consumer and the RAM.
interface ram_read_shim_if #(
    parameter int DAT_WID  = 24,
    parameter int RAM_WORD = 16,
    parameter int RAM_WID  = 32
);
    logic                       fetch;
    logic                       rewind;
    logic signed [DAT_WID-1:0]  data;
    logic                       finished;
    logic [RAM_WID-1:0]         addr;
    logic                       read;
    logic [RAM_WORD-1:0]        word;
    logic                       valid;
`ifdef RAM_SIGN_CHECK_EN
    logic                       sign_err;
`endif

    modport master (
        input  fetch, rewind, word, valid,
`ifdef RAM_SIGN_CHECK_EN
        output sign_err,
`endif
        output data, finished, addr, read
    );

    modport slave (
        output fetch, rewind, word, valid,
`ifdef RAM_SIGN_CHECK_EN
        input  sign_err,
`endif
        input  data, finished, addr, read
    );

endinterface

// File: rtl/ram_read_shim.sv
// ram_read_shim: fetches two consecutive RAM words (low word first) from a
// linear buffer at BASE_ADDR and reassembles them into one signed sample.
//   clk   - system clock
//   rst_n - synchronous reset, active-low
//   bus   - ram_read_shim_if.master (fetch/rewind/data/finished,
//           addr/read/word/valid, optional sign_err)
// The RAM_SIGN_CHECK_EN macro enables a sticky check that each high word is
// a valid sign extension of the sample.
//
// state | meaning
// IDLE  | waiting for fetch; rewind zeroes the offset
// LOW   | read request for the low word is outstanding
// HIGH  | one gap cycle, then read request for the high word is outstanding
// DONE  | sample is valid; wait for fetch to drop
module ram_read_shim
    import ram_shim_pkg::*;
#(
    parameter int                 RAM_WID      = 32,
    parameter logic [RAM_WID-1:0] BASE_ADDR    = RAM_WID'(32'h0100_0000),
    parameter int                 MAX_BYTE_WID = 13,
    parameter int                 DAT_WID      = 24,
    parameter int                 RAM_WORD     = 16,
    parameter int                 ADDR_STEP    = ADDR_STEP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    ram_read_shim_if.master  bus
);

    localparam int HI_WID = DAT_WID - RAM_WORD;
    localparam logic [MAX_BYTE_WID-1:0] STEP = MAX_BYTE_WID'(ADDR_STEP);

    logic [1:0]                state;
    logic [MAX_BYTE_WID-1:0]   offset;
    logic [RAM_WORD-1:0]       low_word;
    logic signed [DAT_WID-1:0] data_q;
    logic                      read_q;
    logic                      finished_q;

`ifdef RAM_SIGN_CHECK_EN
    // The sample's sign bit and every bit above it in the high word must agree.
    localparam int SX_WID = RAM_WORD - HI_WID + 1;
    logic              sign_err_q;
    logic [SX_WID-1:0] sx_bits;
    logic              sx_bad;

    assign sx_bits      = bus.word[RAM_WORD-1:HI_WID-1];
    assign sx_bad       = !((&sx_bits) || !(|sx_bits));
    assign bus.sign_err = sign_err_q;
`endif

    // The offset wraps silently, which keeps addr inside the buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            offset     <= '0;
            low_word   <= '0;
            data_q     <= '0;
            read_q     <= 1'b0;
            finished_q <= 1'b0;
`ifdef RAM_SIGN_CHECK_EN
            sign_err_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.rewind) begin
                        offset <= '0;
`ifdef RAM_SIGN_CHECK_EN
                        sign_err_q <= 1'b0;
`endif
                    end else if (bus.fetch) begin
                        read_q <= 1'b1;
                        state  <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (read_q && bus.valid) begin
                        low_word <= bus.word;
                        read_q   <= 1'b0;
                        offset   <= offset + STEP;
                        state    <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (!read_q) begin
                        // The RAM port requires one idle cycle between requests.
                        read_q <= 1'b1;
                    end else if (bus.valid) begin
                        data_q     <= {bus.word[HI_WID-1:0], low_word};
                        read_q     <= 1'b0;
                        offset     <= offset + STEP;
                        finished_q <= 1'b1;
                        state      <= ST_DONE;
`ifdef RAM_SIGN_CHECK_EN
                        if (sx_bad) sign_err_q <= 1'b1;
`endif
                    end
                end
                ST_DONE: begin
                    if (!bus.fetch) begin
                        finished_q <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.addr     = RAM_WID'(shim_addr(64'(BASE_ADDR), 64'(offset)));
    assign bus.read     = read_q;
    assign bus.data     = data_q;
    assign bus.finished = finished_q;

endmodule

// File: tb/tb_ram_read_shim.sv
module tb_ram_read_shim;

    localparam logic [31:0] BASE     = 32'h0100_0000;
    localparam int          BUF_SIZE = 8192;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    ram_read_shim_if #(.DAT_WID(24), .RAM_WORD(16), .RAM_WID(32)) bus ();

    ram_read_shim dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: a sparse memory and a responder with a programmable delay.
    logic [15:0] mem [logic [31:0]];
    int          ram_delay = 0;
    bit          valid_tie = 1'b0;
    int          wait_cnt  = 0;

    function automatic logic [15:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[15:0] ^ 16'hA5A5;
    endfunction

    always @(posedge clk) begin
        #1;
        if (valid_tie) begin
            bus.valid = 1'b1;
            bus.word  = mem_rd(bus.addr);
        end else if (bus.read) begin
            if (wait_cnt >= ram_delay) begin
                bus.valid = 1'b1;
                bus.word  = mem_rd(bus.addr);
            end else begin
                bus.valid = 1'b0;
                bus.word  = 16'hxxxx;
            end
            wait_cnt++;
        end else begin
            bus.valid = 1'b0;
            wait_cnt  = 0;
        end
    end

    // Reference: the offset as a plain byte count modulo the buffer size.
    int model_off = 0;

    function automatic logic [23:0] exp_sample(input logic [15:0] lo, input logic [15:0] hi);
        return 24'(((32'(hi) % 256) * 65536) + 32'(lo));
    endfunction

    function automatic logic [31:0] exp_addr(input int off);
        return BASE + 32'(off % BUF_SIZE);
    endfunction

    // Runs one full fetch transaction and reports what was seen.
    task automatic do_fetch(input bit rw_high, output logic [23:0] d, output int k,
                            output logic [31:0] a_lo, output logic [31:0] a_hi,
                            output int nhi, output int ngap, output bit to);
        int nv = 0;
        int rw_cnt = 0;
        k = 0; nhi = 0; ngap = 0; to = 1'b0; a_lo = '0; a_hi = '0;
        @(negedge clk);
        bus.fetch = 1'b1;
        forever begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (rw_cnt > 0) begin
                rw_cnt--;
                if (rw_cnt == 0) bus.rewind = 1'b0;
            end
            if (bus.finished) break;
            if (bus.read) nhi++;
            else if (nhi > 0) begin
                ngap++;
                if (rw_high) begin
                    bus.rewind = 1'b1;
                    rw_cnt = 2;
                end
            end
            if (bus.read && bus.valid) begin
                if (nv == 0) a_lo = bus.addr; else a_hi = bus.addr;
                nv++;
            end
            if (k > 300) begin
                to = 1'b1;
                break;
            end
        end
        d = bus.data;
        bus.fetch  = 1'b0;
        bus.rewind = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rewind_pulse();
        @(negedge clk);
        bus.rewind = 1'b1;
        @(negedge clk);
        bus.rewind = 1'b0;
        model_off = 0;
    endtask

    task automatic test_reset();
        valid_tie = 1'b1;
        rst_n = 1'b0;
        bus.fetch = 1'b0;
        bus.rewind = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        model_off = 0;
        checks++; if (bus.read !== 1'b0) begin errors++; $display("FAIL reset_read got=%b exp=0", bus.read); end
        checks++; if (bus.finished !== 1'b0) begin errors++; $display("FAIL reset_finished got=%b exp=0", bus.finished); end
        checks++; if (bus.data !== 24'h0) begin errors++; $display("FAIL reset_data got=%h exp=000000", bus.data); end
        checks++; if (bus.addr !== BASE) begin errors++; $display("FAIL reset_addr got=%h exp=%h", bus.addr, BASE); end
    endtask

    task automatic test_basic();
        logic [23:0] d; int k, nhi, ngap; logic [31:0] lo, hi; bit to;
        mem[exp_addr(0)] = 16'h5678;
        mem[exp_addr(8)] = 16'h0012;
        valid_tie = 1'b1;
        do_fetch(1'b0, d, k, lo, hi, nhi, ngap, to);
        model_off += 16;
        checks++; if (to) begin errors++; $display("FAIL basic_timeout got=timeout exp=finished"); end
        checks++; if (d !== 24'h125678) begin errors++; $display("FAIL basic_data got=%h exp=125678", d); end
        checks++; if (k !== 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4", k); end
        checks++; if (lo !== 32'h0100_0000) begin errors++; $display("FAIL basic_addr_lo got=%h exp=01000000", lo); end
        checks++; if (hi !== 32'h0100_0008) begin errors++; $display("FAIL basic_addr_hi got=%h exp=01000008", hi); end
        checks++; if (bus.addr !== exp_addr(16)) begin errors++; $display("FAIL basic_next_addr got=%h exp=%h", bus.addr, exp_addr(16)); end
        checks++; if (bus.finished !== 1'b0) begin errors++; $display("FAIL basic_finished_drop got=%b exp=0", bus.finished); end
        valid_tie = 1'b0;
    endtask

    task automatic test_negative();
        logic [23:0] d; int k, nhi, ngap; logic [31:0] lo, hi; bit to;
        mem[exp_addr(model_off)]     = 16'hFFFF;
        mem[exp_addr(model_off + 8)] = 16'hFF80;
        do_fetch(1'b0, d, k, lo, hi, nhi, ngap, to);
        model_off += 16;
        checks++; if (d !== 24'h80FFFF) begin errors++; $display("FAIL neg_data got=%h exp=80ffff", d); end
        checks++; if (!($signed(bus.data) < 0)) begin errors++; $display("FAIL neg_sign got=%0d exp=negative", $signed(bus.data)); end
`ifdef RAM_SIGN_CHECK_EN
        checks++; if (bus.sign_err !== 1'b0) begin errors++; $display("FAIL sx_clean got=%b exp=0", bus.sign_err); end
        mem[exp_addr(model_off)]     = 16'hFFFF;
        mem[exp_addr(model_off + 8)] = 16'h1280;
        do_fetch(1'b0, d, k, lo, hi, nhi, ngap, to);
        model_off += 16;
        checks++; if (d !== 24'h80FFFF) begin errors++; $display("FAIL sx_data got=%h exp=80ffff", d); end
        checks++; if (bus.sign_err !== 1'b1) begin errors++; $display("FAIL sx_err got=%b exp=1", bus.sign_err); end
        rewind_pulse();
        @(negedge clk);
        checks++; if (bus.sign_err !== 1'b0) begin errors++; $display("FAIL sx_clear got=%b exp=0", bus.sign_err); end
`endif
    endtask

    task automatic test_delayed_valid();
        logic [23:0] d; int k, nhi, ngap; logic [31:0] lo, hi; bit to;
        ram_delay = 5;
        mem[exp_addr(model_off)]     = 16'hBEEF;
        mem[exp_addr(model_off + 8)] = 16'h7F3C;
        do_fetch(1'b0, d, k, lo, hi, nhi, ngap, to);
        model_off += 16;
        ram_delay = 0;
        checks++; if (d !== exp_sample(16'hBEEF, 16'h7F3C)) begin errors++; $display("FAIL delay_data got=%h exp=%h", d, exp_sample(16'hBEEF, 16'h7F3C)); end
        checks++; if (k !== 14) begin errors++; $display("FAIL delay_latency got=%0d exp=14", k); end
        checks++; if (nhi !== 12) begin errors++; $display("FAIL delay_read_high got=%0d exp=12", nhi); end
        checks++; if (ngap !== 1) begin errors++; $display("FAIL delay_gap got=%0d exp=1", ngap); end
    endtask

    task automatic test_wrap();
        logic [23:0] d; int k, nhi, ngap; logic [31:0] lo, hi; bit to;
        int bad = 0;
        rewind_pulse();
        for (int i = 0; i < 512; i++) begin
            do_fetch(1'b0, d, k, lo, hi, nhi, ngap, to);
            if (to || lo !== exp_addr(model_off) || hi !== exp_addr(model_off + 8)) bad++;
            model_off = (model_off + 16) % BUF_SIZE;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_walk got=%0d bad exp=0", bad); end
        do_fetch(1'b0, d, k, lo, hi, nhi, ngap, to);
        checks++; if (lo !== 32'h0100_0000) begin errors++; $display("FAIL wrap_addr got=%h exp=01000000", lo); end
        checks++; if (hi !== 32'h0100_0008) begin errors++; $display("FAIL wrap_addr_hi got=%h exp=01000008", hi); end
        model_off = 16;
    endtask

    task automatic test_rewind();
        logic [23:0] d; int k, nhi, ngap; logic [31:0] lo, hi; bit to;
        int n = 0;
        ram_delay = 3;
        do_fetch(1'b1, d, k, lo, hi, nhi, ngap, to);
        ram_delay = 0;
        checks++; if (hi !== exp_addr(model_off + 8)) begin errors++; $display("FAIL rw_high_addr got=%h exp=%h", hi, exp_addr(model_off + 8)); end
        model_off += 16;
        checks++; if (bus.addr !== exp_addr(model_off)) begin errors++; $display("FAIL rw_high_ignored got=%h exp=%h", bus.addr, exp_addr(model_off)); end
        @(negedge clk);
        bus.rewind = 1'b1;
        bus.fetch  = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.rewind = 1'b0;
        checks++; if (bus.read !== 1'b0) begin errors++; $display("FAIL rw_fetch_delay got=%b exp=0", bus.read); end
        checks++; if (bus.addr !== BASE) begin errors++; $display("FAIL rw_zero got=%h exp=%h", bus.addr, BASE); end
        @(posedge clk); @(negedge clk);
        checks++; if (bus.read !== 1'b1) begin errors++; $display("FAIL rw_fetch_late got=%b exp=1", bus.read); end
        while (!bus.finished && n < 50) begin @(posedge clk); @(negedge clk); n++; end
        checks++; if (!bus.finished) begin errors++; $display("FAIL rw_finish got=%b exp=1", bus.finished); end
        bus.fetch = 1'b0;
        @(posedge clk); @(negedge clk);
        model_off = 16;
    endtask

    task automatic test_reset_midflight();
        logic [23:0] d; int k, nhi, ngap; logic [31:0] lo, hi; bit to;
        int n = 0;
        bit seen = 1'b0;
        @(negedge clk);
        bus.fetch = 1'b1;
        while (n < 50) begin
            @(posedge clk); @(negedge clk); n++;
            if (bus.read && bus.valid) seen = 1'b1;
            else if (seen && !bus.read) break;
        end
        ram_delay = 1000;
        @(posedge clk); @(negedge clk);
        checks++; if (bus.read !== 1'b1) begin errors++; $display("FAIL mid_req got=%b exp=1", bus.read); end
        rst_n = 1'b0;
        bus.fetch = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++; if (bus.read !== 1'b0) begin errors++; $display("FAIL mid_read got=%b exp=0", bus.read); end
        checks++; if (bus.finished !== 1'b0) begin errors++; $display("FAIL mid_finished got=%b exp=0", bus.finished); end
        checks++; if (bus.data !== 24'h0) begin errors++; $display("FAIL mid_data got=%h exp=000000", bus.data); end
        checks++; if (bus.addr !== BASE) begin errors++; $display("FAIL mid_offset got=%h exp=%h", bus.addr, BASE); end
        rst_n = 1'b1;
        ram_delay = 0;
        model_off = 0;
        do_fetch(1'b0, d, k, lo, hi, nhi, ngap, to);
        checks++; if (lo !== BASE) begin errors++; $display("FAIL mid_refetch got=%h exp=%h", lo, BASE); end
        model_off = 16;
    endtask

    task automatic test_random();
        logic [23:0] d; int k, nhi, ngap; logic [31:0] lo, hi; bit to;
        logic [15:0] wl, wh;
        int dl;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) rewind_pulse();
            dl = int'($urandom_range(0, 3));
            ram_delay = dl;
            wl = 16'($urandom);
            wh = 16'($urandom);
            mem[exp_addr(model_off)]     = wl;
            mem[exp_addr(model_off + 8)] = wh;
            do_fetch(1'b0, d, k, lo, hi, nhi, ngap, to);
            checks++; if (d !== exp_sample(wl, wh)) begin errors++; $display("FAIL rnd_data[%0d] got=%h exp=%h", i, d, exp_sample(wl, wh)); end
            checks++; if (lo !== exp_addr(model_off) || hi !== exp_addr(model_off + 8)) begin
                errors++; $display("FAIL rnd_addr[%0d] got=%h/%h exp=%h/%h", i, lo, hi, exp_addr(model_off), exp_addr(model_off + 8)); end
            checks++; if (k !== 4 + 2 * dl) begin errors++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", i, k, 4 + 2 * dl); end
            model_off = (model_off + 16) % BUF_SIZE;
        end
        ram_delay = 0;
    endtask

    initial begin
        bus.fetch  = 1'b0;
        bus.rewind = 1'b0;
        bus.valid  = 1'b0;
        bus.word   = '0;
        rst_n      = 1'b0;
        test_reset();
        test_basic();
        test_negative();
        test_delayed_valid();
        test_rewind();
        test_reset_midflight();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "time limit");
    end

endmodule
